// File: rtl/fir_interpolator_if.sv
// fir_interpolator_if: sample strobe/data in, strobed output stream and status out.
interface fir_interpolator_if #(
    parameter int num_of_bits_io = 16
);
    logic tick_i;
    logic signed [num_of_bits_io-1:0] signal_i;
    logic signed [num_of_bits_io-1:0] signal_o;
    logic valid_o;
    logic busy_o;
    logic overrun_o;
    modport master (output tick_i, signal_i, input signal_o, valid_o, busy_o, overrun_o);
    modport slave (input tick_i, signal_i, output signal_o, valid_o, busy_o, overrun_o);
endinterface

// File: rtl/fir_interpolator.sv
// fir_interpolator: polyphase interpolating FIR, one saturating MAC iterated over taps and phases.
// FIR_INTERP_PENDING_EN adds a one-deep pending sample buffer and a sticky overrun flag.
module fir_interpolator #(
    parameter int num_of_bits_internal = 18,
    parameter int num_of_bits_io = 16,
    parameter int phases = 2,
    parameter int taps_per_phase = 2,
    parameter logic signed [num_of_bits_internal-1:0] coeffs [phases*taps_per_phase] = '{default: '0}
) (
    input logic clk_i,
    input logic rst_i,
    fir_interpolator_if.slave sif
);
    localparam int W = num_of_bits_internal;
    localparam int IO = num_of_bits_io;
    localparam int T = taps_per_phase;
    localparam int KW = T > 1 ? $clog2(T) : 1;
    localparam int PHW = $clog2(phases);
    localparam int NW = $clog2(phases * T);

    typedef enum logic [1:0] {IDLE, ITERATE, EMIT} state_t;
    state_t state, state_n;
    logic [KW-1:0] k, k_n;
    logic [PHW-1:0] phase, phase_n;
    logic signed [W-1:0] acc, acc_n, acc_sat, coeff;
    logic signed [IO-1:0] in_reg [T];
    logic signed [IO-1:0] in_reg_n [T];
    logic signed [IO-1:0] out_n, start_data;
    logic signed [W+IO-1:0] prod;
    logic signed [W:0] sum;
    logic valid_n, start, last_k, last_phase;
`ifdef FIR_INTERP_PENDING_EN
    logic pend_v, pend_v_n, ovr, ovr_n, take_pend, store_pend, lost;
    logic signed [IO-1:0] pend_d, pend_d_n;
    assign sif.overrun_o = ovr;
`else
    assign sif.overrun_o = 1'b0;
`endif
    assign sif.busy_o = state != IDLE;

    always_comb begin
        last_k = k == KW'(T - 1);
        last_phase = phase == PHW'(phases - 1);
        coeff = coeffs[NW'(k * phases + phase)];
        prod = (W+IO)'(coeff) * (W+IO)'(in_reg[k]);
        sum = (W+1)'(acc) + (W+1)'(prod >>> (IO - 1));
        acc_sat = (sum[W] != sum[W-1]) ? {sum[W], {(W-1){~sum[W]}}} : sum[W-1:0];
        out_n = (&acc[W-1:IO-1] || !(|acc[W-1:IO-1])) ? acc[IO-1:0] : {acc[W-1], {(IO-1){~acc[W-1]}}};
        valid_n = state == EMIT;
`ifdef FIR_INTERP_PENDING_EN
        // A pending sample is consumed in IDLE or in the final EMIT, freeing the slot for a same-cycle tick
        take_pend = pend_v && (state == IDLE || (state == EMIT && last_phase));
        start = take_pend || (state == IDLE && sif.tick_i);
        start_data = take_pend ? pend_d : sif.signal_i;
        store_pend = sif.tick_i && (state != IDLE || take_pend);
        lost = store_pend && pend_v && !take_pend;
        pend_v_n = (store_pend && !lost) || (pend_v && !take_pend);
        pend_d_n = (store_pend && !lost) ? sif.signal_i : pend_d;
        ovr_n = ovr || lost;
`else
        start = state == IDLE && sif.tick_i;
        start_data = sif.signal_i;
`endif
        state_n = state;
        k_n = k;
        phase_n = phase;
        acc_n = acc;
        in_reg_n = in_reg;
        case (state)
            IDLE: acc_n = '0;
            ITERATE: begin
                acc_n = acc_sat;
                k_n = last_k ? k : k + 1'b1;
                state_n = last_k ? EMIT : ITERATE;
            end
            EMIT: begin
                acc_n = '0;
                k_n = '0;
                phase_n = last_phase ? '0 : phase + 1'b1;
                state_n = last_phase ? IDLE : ITERATE;
            end
            default: state_n = IDLE;
        endcase
        if (start) begin
            for (int i = T - 1; i > 0; i--) in_reg_n[i] = in_reg[i-1];
            in_reg_n[0] = start_data;
            phase_n = '0;
            k_n = '0;
            state_n = ITERATE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            k <= '0;
            phase <= '0;
            acc <= '0;
            in_reg <= '{default: '0};
            sif.signal_o <= '0;
            sif.valid_o <= 1'b0;
`ifdef FIR_INTERP_PENDING_EN
            pend_v <= 1'b0;
            pend_d <= '0;
            ovr <= 1'b0;
`endif
        end else begin
            state <= state_n;
            k <= k_n;
            phase <= phase_n;
            acc <= acc_n;
            in_reg <= in_reg_n;
            sif.valid_o <= valid_n;
            if (valid_n) sif.signal_o <= out_n;
`ifdef FIR_INTERP_PENDING_EN
            pend_v <= pend_v_n;
            pend_d <= pend_d_n;
            ovr <= ovr_n;
`endif
        end
    end
endmodule

// File: tb/tb_fir_interpolator.sv
// tb_fir_interpolator: directed vectors on two instances (scaling coeffs and saturating coeffs).
module tb_fir_interpolator;
    localparam int IO = 16;
    localparam int INT = 18;
    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic tick = 1'b0;
    logic signed [IO-1:0] sig = '0;
    int n_cmp = 0;
    int n_err = 0;
    logic va [40];
    logic busy_a [40];
    logic ovr_a [40];
    int sa [40];
    int sb [40];
    logic snap_v, snap_b;
    int snap_s;

    always #5 clk_i = ~clk_i;

    fir_interpolator_if #(.num_of_bits_io(IO)) ia ();
    fir_interpolator_if #(.num_of_bits_io(IO)) ib ();
    assign ia.tick_i = tick;
    assign ia.signal_i = sig;
    assign ib.tick_i = tick;
    assign ib.signal_i = sig;

    fir_interpolator #(
        .num_of_bits_internal(INT), .num_of_bits_io(IO), .phases(2), .taps_per_phase(2),
        .coeffs('{18'sd32768, 18'sd16384, 18'sd8192, 18'sd4096})
    ) dut_a (.clk_i(clk_i), .rst_i(rst_i), .sif(ia));

    fir_interpolator #(
        .num_of_bits_internal(INT), .num_of_bits_io(IO), .phases(2), .taps_per_phase(2),
        .coeffs('{18'sd131071, 18'sd0, 18'sd131071, 18'sd0})
    ) dut_b (.clk_i(clk_i), .rst_i(rst_i), .sif(ib));

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Cycle c is sampled at its negedge before that cycle's inputs are driven
    task automatic run(input int n, input int tc0, input int d0, input int tc1, input int d1,
                       input int tc2, input int d2, input int rc);
        for (int c = 0; c < n; c++) begin
            @(negedge clk_i);
            va[c] = ia.valid_o;
            busy_a[c] = ia.busy_o;
            ovr_a[c] = ia.overrun_o;
            sa[c] = int'(ia.signal_o);
            sb[c] = int'(ib.signal_o);
            tick = (c == tc0) || (c == tc1) || (c == tc2);
            sig = c == tc0 ? IO'(d0) : c == tc1 ? IO'(d1) : c == tc2 ? IO'(d2) : '0;
            rst_i = c == rc;
            if (c == rc) begin
                #1;
                snap_v = ia.valid_o;
                snap_b = ia.busy_o;
                snap_s = int'(ia.signal_o);
            end
        end
    endtask

    function automatic int count_va(input int n);
        int s = 0;
        for (int i = 0; i < n; i++) s += va[i] ? 1 : 0;
        return s;
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk_i);
        check("rst_signal", int'(ia.signal_o), 0);
        check("rst_valid", int'(ia.valid_o), 0);
        check("rst_busy", int'(ia.busy_o), 0);
        check("rst_overrun", int'(ia.overrun_o), 0);
        rst_i = 1'b0;
        run(4, -1, 0, -1, 0, -1, 0, -1);

        run(18, 0, 1000, 7, 0, -1, 0, -1);
        check("t1_busy0", int'(busy_a[0]), 0);
        check("t1_busy1", int'(busy_a[1]), 1);
        check("t1_busy6", int'(busy_a[6]), 1);
        check("t1_busy7", int'(busy_a[7]), 0);
        check("t1_v4", int'(va[4]), 1);
        check("t1_v5", int'(va[5]), 0);
        check("t1_s4", sa[4], 1000);
        check("t1_s7", sa[7], 500);
        check("t1_s11", sa[11], 250);
        check("t1_s14", sa[14], 125);
        check("t1_nvalid", count_va(18), 4);

        run(10, 0, -1000, -1, 0, -1, 0, -1);
        check("t2_s4", sa[4], -1000);
        check("t2_s7", sa[7], -500);
        check("t2_nvalid", count_va(10), 2);

        run(12, 0, 1000, -1, 0, -1, 0, 2);
        check("t3_rst_signal", snap_s, 0);
        check("t3_rst_valid", int'(snap_v), 0);
        check("t3_rst_busy", int'(snap_b), 0);
        check("t3_nvalid", count_va(12), 0);

        run(10, 0, 1000, -1, 0, -1, 0, -1);
        check("t4_s4", sa[4], 1000);
        check("t4_s7", sa[7], 500);

        run(3, -1, 0, -1, 0, -1, 0, 1);
        run(16, 0, 32767, 7, 32767, -1, 0, -1);
        check("t5_s4", sb[4], 32767);
        check("t5_s7", sb[7], 0);
        check("t5_s11", sb[11], 32767);
        check("t5_s14", sb[14], 0);

        run(3, -1, 0, -1, 0, -1, 0, 1);
        run(16, 0, -32768, 7, -32768, -1, 0, -1);
        check("t6_s4", sb[4], -32768);
        check("t6_s11", sb[11], -32768);

        run(3, -1, 0, -1, 0, -1, 0, 1);
        run(20, 0, 1000, 3, 2000, 4, 3000, -1);
        check("t7_s4", sa[4], 1000);
        check("t7_s7", sa[7], 500);
        check("t7_ovr4", int'(ovr_a[4]), 0);
`ifdef FIR_INTERP_PENDING_EN
        check("t7_ovr5", int'(ovr_a[5]), 1);
        check("t7_busy7", int'(busy_a[7]), 1);
        check("t7_v10", int'(va[10]), 1);
        check("t7_s10", sa[10], 2250);
        check("t7_s13", sa[13], 1125);
        check("t7_ovr19", int'(ovr_a[19]), 1);
        check("t7_nvalid", count_va(20), 4);
`else
        check("t7_ovr5", int'(ovr_a[5]), 0);
        check("t7_busy7", int'(busy_a[7]), 0);
        check("t7_ovr19", int'(ovr_a[19]), 0);
        check("t7_nvalid", count_va(20), 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/fir_interpolator.md
# fir_interpolator

Time-multiplexed polyphase interpolating FIR filter: for each input sample strobe it computes `phases` output samples, one per polyphase branch, with a single saturating multiply-add unit iterated over `taps_per_phase` coefficients. It is the upsampling counterpart of the decimating FIR chain. It sits on the synthesis/stimulus path, taking low-rate samples and producing a `valid_o`-strobed high-rate stream for the downstream DAC or modulator.

## Interface
- `num_of_bits_internal`, 18: accumulator and coefficient width (signed).
- `num_of_bits_io`, 16: input and output sample width (signed).
- `phases`, 2: interpolation factor L, ≥2.
- `taps_per_phase`, 2: taps per polyphase branch, ≥1; total taps N = phases·taps_per_phase.
- `coeffs[N]`, all 0: signed coefficients; unity gain = 2^(num_of_bits_io-1).
- `clk_i` in 1: single clock, all state on rising edge.
- `rst_i` in 1: asynchronous, active-high reset.
- `tick_i` in 1: input sample strobe, one cycle per sample.
- `signal_i` in num_of_bits_io: input sample, sampled when `tick_i` is accepted.
- `signal_o` out num_of_bits_io: output sample, held between updates.
- `valid_o` out 1: one-cycle pulse per new `signal_o`.
- `busy_o` out 1: high whenever state ≠ IDLE.
- `overrun_o` out 1: sticky lost-sample flag (see Configuration).

## Operation
- Input history `in_reg[0..taps_per_phase-1]`: shifts on accepted tick, `in_reg[0]` ← `signal_i`.
- Branch p, tap k uses `coeffs[k·phases + p]` × `in_reg[k]`.
- MAC: product full width (internal+io bits), arithmetic shift right by io-1, add to accumulator in internal+1 bits, saturate to internal range [-2^(int-1), 2^(int-1)-1].
- Output: accumulator saturated to io range [-2^(io-1), 2^(io-1)-1].
- FSM states:
  - IDLE: accumulator cleared. `tick_i` → shift, phase=0, k=0, go ITERATE.
  - ITERATE: accumulate one tap per cycle; k==taps_per_phase-1 → EMIT, else k+1.
  - EMIT: `signal_o` ← sat(acc), `valid_o` ← 1 (registered); clear acc, k=0; phase==phases-1 → IDLE (or pending-sample start, see Configuration), else phase+1 → ITERATE.
- Ticks while busy are not accepted; history and output unaffected.
- Reset values: `signal_o`=0, `valid_o`=0, `busy_o`=0, `overrun_o`=0, history, accumulator, phase, k all 0, state IDLE.
- Reset mid-operation: everything cleared asynchronously, no further `valid_o` for the aborted sample.

## Timing
- Tick accepted in cycle 0. With T=taps_per_phase: ITERATE cycles 1..T, EMIT cycle T+1, `valid_o` high in cycle T+2.
- Branch p output: `valid_o` in cycle (p+1)(T+1)+1.
- Busy span: cycles 1..phases·(T+1); `busy_o` low again in cycle phases·(T+1)+1.
- Minimum tick spacing without loss: phases·(T+1)+1 cycles. Defaults: 7 cycles, valid at cycles 4 and 7.
- `valid_o` never high in two consecutive cycles.

## Configuration
- `FIR_INTERP_PENDING_EN` defined: one-deep pending buffer. A tick while busy latches `signal_i` as pending. In the final EMIT, if pending exists: shift it in, phase=0, go straight to ITERATE with no IDLE cycle. A tick while busy with pending already full sets `overrun_o` (sticky until reset) and is discarded. A tick in the same cycle as that final EMIT goes to pending.
- Not defined: busy ticks are silently dropped; `overrun_o` tied 0; no pending storage.

## Test plan
- Defaults, coeffs {32768,16384,8192,4096}; tick 1000, then tick 0 after 7 cycles -> `signal_o` sequence 1000, 500, 250, 125 at cycles 4, 7, 11, 14.
- Same coeffs, tick −1000 -> outputs −1000, −500 (arithmetic shift, exact).
- coeffs {131071,0,131071,0}; ticks 32767, 32767 -> second tick phase 0 internal saturates at 131071, `signal_o`=32767. Same with −32768 -> −32768.
- Tick 1000, assert `rst_i` in cycle 2 -> `signal_o`=0, `valid_o`=0, `busy_o`=0 immediately, no pulse at cycle 4. Next tick 1000 -> 1000, 500 with no history term.
- Without macro: tick 1000 at cycle 0, tick 2000 at cycle 3 -> only 1000, 500 emitted, `overrun_o`=0.
- With `FIR_INTERP_PENDING_EN`: ticks at 0, 3, 4 -> 1000, 500, then the cycle-3 sample branch outputs start with `valid_o` at cycle 10; `overrun_o`=1 from cycle 5.
